// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, addresses the instruction ROM and fills the IF/ID register.
// Handles stall, flush and redirect, and halts with a sticky fault on a misaligned or out-of-map PC.
module imem_fetch_ctrl #(
    parameter int                   A_WIDTH   = 12,
    parameter int                   EXT_WIDTH = 32,
    parameter logic [EXT_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [EXT_WIDTH-1:0] NOP_INSTR = EXT_WIDTH'(32'h00000013)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 redirect_i,
    input  logic [EXT_WIDTH-1:0] redirect_pc_i,
    output logic [EXT_WIDTH-1:0] imem_addr_o,
    input  logic [EXT_WIDTH-1:0] imem_rd_i,
    output logic [EXT_WIDTH-1:0] instr_o,
    output logic [EXT_WIDTH-1:0] pc_o,
    output logic [EXT_WIDTH-1:0] pc_plus4_o,
    output logic                 valid_o,
    output logic                 fault_o,
    output logic [EXT_WIDTH-1:0] fault_pc_o,
    output logic [31:0]          fetch_cnt_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Highest word-aligned address inside the ROM map.
    localparam logic [EXT_WIDTH-1:0] MAX_PC = EXT_WIDTH'((64'd1 << A_WIDTH) - 64'd4);

    state_t               state;
    logic [EXT_WIDTH-1:0] pc;
    logic [EXT_WIDTH-1:0] pc_plus4;
    logic                 bad_pc;

    assign imem_addr_o = pc;
    assign pc_plus4    = pc + EXT_WIDTH'(4);
    assign bad_pc      = (pc[1:0] != 2'b00) || ((pc >> A_WIDTH) != '0) || (pc > MAX_PC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr_o     <= NOP_INSTR;
            pc_o        <= '0;
            pc_plus4_o  <= '0;
            valid_o     <= 1'b0;
            fault_o     <= 1'b0;
            fault_pc_o  <= '0;
            fetch_cnt_o <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= RUN;
                    instr_o <= NOP_INSTR;
                    valid_o <= 1'b0;
                end
                RUN: begin
                    if (bad_pc) begin
                        state      <= HALT;
                        instr_o    <= NOP_INSTR;
                        valid_o    <= 1'b0;
                        fault_o    <= 1'b1;
                        fault_pc_o <= pc;
                    end else begin
                        if (redirect_i) begin
                            pc <= redirect_pc_i;
                        end else if (!stall_i) begin
                            pc <= pc_plus4;
                        end

                        // Flush beats stall; an unstalled redirect squashes the wrong-path word.
                        if (flush_i || (!stall_i && redirect_i)) begin
                            instr_o <= NOP_INSTR;
                            valid_o <= 1'b0;
                        end else if (!stall_i) begin
                            instr_o    <= imem_rd_i;
                            pc_o       <= pc;
                            pc_plus4_o <= pc_plus4;
                            valid_o    <= 1'b1;
                            if (fetch_cnt_o != 32'hFFFF_FFFF) begin
                                fetch_cnt_o <= fetch_cnt_o + 32'd1;
                            end
                        end
                    end
                end
                HALT: begin
                    instr_o <= NOP_INSTR;
                    valid_o <= 1'b0;
                end
                default: begin
                    state   <= BOOT;
                    instr_o <= NOP_INSTR;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
